// File: rtl/ps2_kbd_rx_pkg.sv
// rtl/ps2_kbd_rx_pkg.sv - shared constants and receiver state encoding for the PS/2 keyboard receiver
package ps2_kbd_rx_pkg;

    localparam int KbWidth     = 8;
    localparam int Ps2FrameLen = 11;
    localparam int Ps2CntW     = $clog2(Ps2FrameLen);

    // Receiver phases: waiting for start, collecting data, parity, stop
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones
    function automatic logic odd_parity_ok(input logic [KbWidth-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 device-to-host frame receiver with synchronizers and stall timeout
module ps2_frame_rx
    import ps2_kbd_rx_pkg::*;
#(
    parameter int TIMEOUT = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    output logic [KbWidth-1:0] rx_byte,
    output logic               rx_valid,
    output logic               rx_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic clk_s1, clk_s2, clk_s3;
    logic data_s1, data_s2;
    logic fe;

    rx_state_t          state, state_n;
    logic [Ps2CntW-1:0] cnt, cnt_n;
    logic [KbWidth-1:0] shift, shift_n;
    logic               par, par_n;
    logic [TW-1:0]      tcnt, tcnt_n;
    logic [KbWidth-1:0] byte_q, byte_n;
    logic               valid_n, err_n;

    // Bring the pad clock and data into the clk domain; idle line level is 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fe = clk_s3 & ~clk_s2;

    // Receiver state, bit counter, shift register, timeout and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            shift    <= '0;
            par      <= 1'b0;
            tcnt     <= '0;
            byte_q   <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            shift    <= shift_n;
            par      <= par_n;
            tcnt     <= tcnt_n;
            byte_q   <= byte_n;
            rx_valid <= valid_n;
            rx_err   <= err_n;
        end
    end

    // Next-state logic: one frame bit per falling edge, stop bit validates the frame
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shift_n = shift;
        par_n   = par;
        tcnt_n  = tcnt;
        byte_n  = byte_q;
        valid_n = 1'b0;
        err_n   = 1'b0;

        if (state != RX_IDLE) begin
            tcnt_n = fe ? '0 : tcnt + TW'(1);
        end

        case (state)
            RX_IDLE: begin
                tcnt_n = '0;
                if (fe && !data_s2) begin
                    state_n = RX_DATA;
                    cnt_n   = Ps2CntW'(1);
                    shift_n = '0;
                end
            end
            RX_DATA: begin
                if (fe) begin
                    shift_n = {data_s2, shift[KbWidth-1:1]};
                    cnt_n   = cnt + Ps2CntW'(1);
                    if (cnt == Ps2CntW'(KbWidth)) begin
                        state_n = RX_PARITY;
                    end
                end
            end
            RX_PARITY: begin
                if (fe) begin
                    par_n   = data_s2;
                    cnt_n   = cnt + Ps2CntW'(1);
                    state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fe) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    if (data_s2 && odd_parity_ok(shift, par)) begin
                        valid_n = 1'b1;
                        byte_n  = shift;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = RX_IDLE;
                cnt_n   = '0;
            end
        endcase

        // A stalled frame is silently abandoned
        if (state != RX_IDLE && !fe && tcnt == TW'(TIMEOUT - 1)) begin
            state_n = RX_IDLE;
            cnt_n   = '0;
            shift_n = '0;
            tcnt_n  = '0;
        end
    end

    assign rx_byte = byte_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver with show-ahead scan code FIFO for MMIO reads
module ps2_kbd_rx
    import ps2_kbd_rx_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               rd_pop,
    output logic [KbWidth-1:0] kb_rdata,
    output logic               kb_ready,
    output logic               frame_err,
    output logic               overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [KbWidth-1:0] rx_byte;
    logic               rx_valid;
    logic               rx_err;

    logic               push_q;
    logic [KbWidth-1:0] push_data_q;

    logic [KbWidth-1:0] mem [DEPTH];
    logic [AW-1:0]      wptr, rptr;
    logic [AW:0]        count;
    logic               full, do_pop, do_push;

    ps2_frame_rx #(
        .TIMEOUT (TIMEOUT)
    ) u_frame_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    assign frame_err = rx_err;

    // Retime the receiver's push request so the FIFO write is one stage removed from the FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q      <= rx_valid;
            push_data_q <= rx_byte;
        end
    end

    assign full     = (count == (AW+1)'(DEPTH));
    assign kb_ready = (count != '0);
    assign do_pop   = rd_pop & kb_ready;
    assign do_push  = push_q & (~full | do_pop);
    assign kb_rdata = kb_ready ? mem[rptr] : '0;

    // FIFO storage is deliberately left uninitialised by reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data_q;
        end
    end

    // Pointers, occupancy and sticky drop flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
            if (push_q && full && !do_pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Upstream keyboard source for the MMIO read path: receives PS/2 device-to-host frames and validates them.
- Buffers scan codes in a show-ahead FIFO.
- Presents the head byte as kb_rdata with kb_ready, and pops one entry per cycle in which the MMIO asserts its keyboard-read strobe.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TIMEOUT, 50000, clk cycles without a ps2_clk falling edge mid-frame before the frame is abandoned.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ps2_clk  in  1  raw PS/2 clock from the pad; asynchronous to clk
- ps2_data  in  1  raw PS/2 data from the pad; asynchronous to clk
- rd_pop  in  1  pop strobe from MMIO (its sig_rd_kb); one entry per asserted cycle
- kb_rdata  out  KbWidth(8)  FIFO head scan code; 0 when empty
- kb_ready  out  1  FIFO non-empty
- frame_err  out  1  one-cycle pulse on a rejected frame
- overflow  out  1  sticky; set when a valid frame is dropped because the FIFO is full

Behaviour:
- Reset (async, any time, including mid-frame):
  - Synchronizers load 1; bit counter, shift register and timeout counter clear; FIFO pointers and count clear.
  - Outputs: kb_rdata=0, kb_ready=0, frame_err=0, overflow=0. FIFO storage is not cleared.
- Synchronization:
  - ps2_clk and ps2_data each pass through 2 flops (s1, s2); ps2_clk gets a third flop s3.
  - Falling edge fe = s3 & ~s2. Data is sampled from ps2_data s2 in the fe cycle.
- Frame: 11 bits, one per fe: start(0), D0..D7 LSB first, odd parity, stop(1).
  - Bit counter runs 0..10 and wraps to 0 after the stop bit.
- Receiver states:
  - IDLE: on fe with data=0, go to DATA (cnt=1). On fe with data=1, stay in IDLE (glitch ignored).
  - DATA: shift 8 bits, then go to PARITY.
  - PARITY: latch parity bit, then go to STOP.
  - STOP: on fe, check data=1 and ^{D7..D0,P}=1.
    - Pass: push request, back to IDLE.
    - Fail: frame_err pulses for exactly 1 cycle, no push, back to IDLE.
- Timeout: in any state other than IDLE, the counter increments each cycle without fe and clears on fe. On reaching TIMEOUT: go to IDLE, discard partial bits, no frame_err.
- Latency: the push is registered at the posedge after the STOP fe cycle. kb_ready rises 4 clk posedges after the first posedge that samples the stop-bit ps2_clk low in s1.
- FIFO:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - kb_rdata = mem[rptr] when count>0, else 0 (combinational).
  - kb_ready = (count!=0).
  - A pop takes effect when rd_pop & kb_ready at a posedge.
  - rd_pop while empty is ignored; no underflow, pointers unchanged.
  - Push while full with no pop: frame dropped, overflow<=1 (sticky until rst), count unchanged.
  - Push and pop in the same cycle: both succeed, count unchanged. This holds when full, so no drop and no overflow.
  - Push and pop in the same cycle while empty: the push succeeds, the pop is ignored.
- A pop does not change kb_rdata until after the posedge. The MMIO sees the old head in the strobe cycle.

Decomposition:
- Shared defines/package: KbWidth=8 (existing), PS2 frame length 11, and receiver state encodings IDLE/DATA/PARITY/STOP.
- Sub-module ps2_frame_rx: synchronizers, state machine, timeout. Outputs byte, valid pulse and err pulse.
- Top ps2_kbd_rx instantiates ps2_frame_rx and implements the FIFO inline.

Test Plan:
- Frame 0x1C (parity 0, stop 1), ps2_clk period 1000 clk -> kb_ready=1 at exactly 4 posedges after the stop-edge sample; kb_rdata=0x1C; rd_pop for 1 cycle -> kb_ready=0, kb_rdata=0.
- Frames F0 then 1C, no pop -> head 0xF0. Pop -> 0x1C. Pop -> empty. Extra rd_pop while empty -> no change.
- Frame 0x1C with parity=1 -> frame_err high exactly 1 cycle, kb_ready stays 0.
- Nine frames 0x01..0x09, DEPTH=8, no pops -> overflow=1. Pops return 0x01..0x08, then empty.
- Frame 0x10 delivered while full, with rd_pop asserted in the push cycle -> no overflow; final pop order 0x02..0x08, 0x10.
- Timeout/reset:
  - Send 5 bits, stall TIMEOUT+10 cycles, then a full 0x32 frame -> kb_rdata=0x32, no frame_err.
  - Assert rst mid-frame -> all outputs 0 immediately; the next full frame is received correctly.
